// File: rtl/seq_ctrl_pkg.sv
// Shared encodings for the sequence-scan controller and its match core.
package seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] DEF_PATTERN = 4'b1001;

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: history shift register, fill counter,
// length-masked compare and optional history clear after a match.
module seq_match_core
   import seq_ctrl_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int LEN_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic             overlap,
   output logic             match
);

   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] hist_n;
   logic [PAT_W-1:0] mask;
   logic [LEN_W-1:0] fill;
   logic [LEN_W-1:0] fill_inc;

   always_comb begin
      hist_n   = {hist[PAT_W-2:0], bit_in};
      fill_inc = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
      mask     = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (LEN_W'(i) < len);
      end
      match = bit_valid && (fill_inc >= len) &&
              (((hist_n ^ pattern) & mask) == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist <= '0;
         fill <= '0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
      end else if (bit_valid) begin
         hist <= hist_n;
         // non-overlap: next match needs len fresh bits
         fill <= (match && !overlap) ? '0 : fill_inc;
      end
   end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan controller: FSM, match/bit counters, target and window limits,
// driving a serial pattern matcher.
module seq_scan_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int LEN_W = 3,
   parameter int CNT_W = 8,
   parameter int WIN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic [WIN_W-1:0] cfg_window,
   input  logic             start,
   input  logic             abort,
   input  logic             data_valid,
   input  logic             data,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_cnt,
   output logic [WIN_W-1:0] bit_cnt
);

   state_t state, state_n;

   logic [PAT_W-1:0] pattern_q;
   logic [LEN_W-1:0] len_q;
   logic             overlap_q;
   logic [CNT_W-1:0] target_q;
   logic [WIN_W-1:0] window_q;

   logic             launch;
   logic             vbit;
   logic             match;
   logic [LEN_W-1:0] len_norm;
   logic [CNT_W-1:0] cnt_n;
   logic [WIN_W-1:0] bits_n;
   logic             tgt_hit;
   logic             win_hit;

   always_comb begin
      launch   = (state == ST_IDLE) && start;
      // abort wins: the bit on an abort cycle is never consumed
      vbit     = (state == ST_SCAN) && data_valid && !abort;
      len_norm = cfg_len;
      if (cfg_len == '0 || cfg_len > LEN_W'(PAT_W)) begin
         len_norm = LEN_W'(PAT_W);
      end
      cnt_n = match_cnt;
      if (match && match_cnt != '1) begin
         cnt_n = match_cnt + 1'b1;
      end
      bits_n = bit_cnt;
      if (vbit && bit_cnt != '1) begin
         bits_n = bit_cnt + 1'b1;
      end
      tgt_hit = vbit && (target_q != '0) && (cnt_n == target_q);
      win_hit = vbit && (window_q != '0) && (bits_n == window_q);
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (start) state_n = ST_SCAN;
         ST_SCAN: begin
            if (abort) begin
               state_n = ST_IDLE;
            end else if (tgt_hit || win_hit) begin
               state_n = ST_DONE;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pattern_q   <= PAT_W'(DEF_PATTERN);
         len_q       <= LEN_W'(PAT_W);
         overlap_q   <= 1'b0;
         target_q    <= '0;
         window_q    <= '0;
         match_cnt   <= '0;
         bit_cnt     <= '0;
         match_pulse <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_n;
         match_pulse <= match;
         if (launch) begin
            pattern_q <= cfg_pattern;
            len_q     <= len_norm;
            overlap_q <= cfg_overlap;
            target_q  <= cfg_target;
            window_q  <= cfg_window;
            match_cnt <= '0;
            bit_cnt   <= '0;
            timeout   <= 1'b0;
         end else if (vbit) begin
            match_cnt <= cnt_n;
            bit_cnt   <= bits_n;
            if (win_hit && !tgt_hit) begin
               timeout <= 1'b1;
            end
         end
      end
   end

   assign busy = (state == ST_SCAN);
   assign done = (state == ST_DONE);

   seq_match_core #(
      .PAT_W(PAT_W),
      .LEN_W(LEN_W)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (launch),
      .bit_valid(vbit),
      .bit_in   (data),
      .pattern  (pattern_q),
      .len      (len_q),
      .overlap  (overlap_q),
      .match    (match)
   );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl with a match_pulse scoreboard.
module tb_seq_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  cfg_pattern;
   logic [2:0]  cfg_len;
   logic        cfg_overlap;
   logic [7:0]  cfg_target;
   logic [15:0] cfg_window;
   logic        start, abort, data_valid, data;
   logic        busy, done, timeout, match_pulse;
   logic [7:0]  match_cnt;
   logic [15:0] bit_cnt;

   int total = 0;
   int bad   = 0;
   logic sb[$];

   always #5 clk = ~clk;

   seq_scan_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_pattern(cfg_pattern),
      .cfg_len    (cfg_len),
      .cfg_overlap(cfg_overlap),
      .cfg_target (cfg_target),
      .cfg_window (cfg_window),
      .start      (start),
      .abort      (abort),
      .data_valid (data_valid),
      .data       (data),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .match_pulse(match_pulse),
      .match_cnt  (match_cnt),
      .bit_cnt    (bit_cnt)
   );

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         logic e;
         e = sb.pop_front();
         total++;
         if (match_pulse !== e) begin
            bad++;
            $display("FAIL match_pulse: got %b want %b at %0t",
                     match_pulse, e, $time);
         end
      end
   end

   task automatic cyc(input logic s, input logic a, input logic v,
                      input logic d, input logic exp_mp);
      start = s; abort = a; data_valid = v; data = d;
      @(posedge clk);
      sb.push_back(exp_mp);
      @(negedge clk);
      start = 1'b0; abort = 1'b0; data_valid = 1'b0; data = 1'b0;
   endtask

   task automatic start_scan(input logic [3:0] p, input logic [2:0] l,
                             input logic ov, input logic [7:0] t,
                             input logic [15:0] w);
      cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
      cfg_target = t; cfg_window = w;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      // scrambled cfg after start must not matter
      cfg_pattern = ~p; cfg_len = 3'd1; cfg_overlap = ~ov;
      cfg_target = 8'd1; cfg_window = 16'd1;
   endtask

   task automatic feed(input logic [15:0] bits, input logic [15:0] mexp,
                       input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 1'b0, 1'b1, bits[i], mexp[i]);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      total++;
      if ({busy, done, timeout, match_pulse} !== 4'b0 ||
          match_cnt !== 8'd0 || bit_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset: got b%b d%b t%b m%b c%0d n%0d want all 0",
                  busy, done, timeout, match_pulse, match_cnt, bit_cnt);
      end
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_overlap;
      start_scan(4'b1001, 3'd4, 1'b1, 8'd0, 16'd7);
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL ovl_busy: got %b want 1", busy);
      end
      feed(16'h0049, 16'h0048, 7);
      total++;
      if (done !== 1'b1 || timeout !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL ovl_end: got d%b t%b b%b want d1 t1 b0",
                  done, timeout, busy);
      end
      total++;
      if (match_cnt !== 8'd2 || bit_cnt !== 16'd7) begin
         bad++;
         $display("FAIL ovl_cnt: got %0d/%0d want 2/7", match_cnt, bit_cnt);
      end
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      total++;
      if (done !== 1'b0 || bit_cnt !== 16'd7 || timeout !== 1'b1) begin
         bad++;
         $display("FAIL ovl_after: got d%b n%0d t%b want d0 n7 t1",
                  done, bit_cnt, timeout);
      end
   endtask

   task automatic test_no_overlap;
      start_scan(4'b1001, 3'd4, 1'b0, 8'd0, 16'd7);
      feed(16'h0049, 16'h0008, 7);
      total++;
      if (done !== 1'b1 || timeout !== 1'b1 || match_cnt !== 8'd1) begin
         bad++;
         $display("FAIL novl: got d%b t%b c%0d want d1 t1 c1",
                  done, timeout, match_cnt);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_target;
      start_scan(4'b1001, 3'd4, 1'b1, 8'd2, 16'd0);
      total++;
      if (timeout !== 1'b0) begin
         bad++; $display("FAIL tgt_tmo_clr: got %b want 0", timeout);
      end
      feed(16'h0099, 16'h0088, 8);
      total++;
      if (done !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0 ||
          match_cnt !== 8'd2 || bit_cnt !== 16'd8) begin
         bad++;
         $display("FAIL tgt: got d%b t%b b%b c%0d n%0d want d1 t0 b0 c2 n8",
                  done, timeout, busy, match_cnt, bit_cnt);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_both_limits;
      start_scan(4'b1001, 3'd4, 1'b1, 8'd2, 16'd8);
      feed(16'h0099, 16'h0088, 8);
      total++;
      if (done !== 1'b1 || timeout !== 1'b0) begin
         bad++;
         $display("FAIL both: got d%b t%b want d1 t0", done, timeout);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_abort;
      start_scan(4'b1001, 3'd4, 1'b1, 8'd0, 16'd0);
      feed(16'h0001, 16'h0000, 3);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (busy !== 1'b1 || bit_cnt !== 16'd3) begin
         bad++;
         $display("FAIL abort_start: got b%b n%0d want b1 n3", busy, bit_cnt);
      end
      // the bit on the abort cycle would complete 1001
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 ||
          bit_cnt !== 16'd3 || match_cnt !== 8'd0) begin
         bad++;
         $display("FAIL abort: got b%b d%b t%b n%0d c%0d want b0 d0 t0 n3 c0",
                  busy, done, timeout, bit_cnt, match_cnt);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (done !== 1'b0 || bit_cnt !== 16'd3) begin
         bad++;
         $display("FAIL abort_hold: got d%b n%0d want d0 n3", done, bit_cnt);
      end
   endtask

   task automatic test_len_default;
      start_scan(4'b1001, 3'd0, 1'b1, 8'd1, 16'd0);
      feed(16'h0009, 16'h0008, 4);
      total++;
      if (done !== 1'b1 || match_cnt !== 8'd1 || bit_cnt !== 16'd4) begin
         bad++;
         $display("FAIL len0: got d%b c%0d n%0d want d1 c1 n4",
                  done, match_cnt, bit_cnt);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_short_gapped;
      start_scan(4'b1101, 3'd2, 1'b1, 8'd0, 16'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      total++;
      if (match_cnt !== 8'd2 || bit_cnt !== 16'd4 || busy !== 1'b1) begin
         bad++;
         $display("FAIL short: got c%0d n%0d b%b want c2 n4 b1",
                  match_cnt, bit_cnt, busy);
      end
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if ({busy, done, timeout, match_pulse} !== 4'b0 ||
          match_cnt !== 8'd0 || bit_cnt !== 16'd0) begin
         bad++;
         $display("FAIL midreset: got b%b d%b t%b m%b c%0d n%0d want all 0",
                  busy, done, timeout, match_pulse, match_cnt, bit_cnt);
      end
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_pattern = 4'd0; cfg_len = 3'd0; cfg_overlap = 1'b0;
      cfg_target = 8'd0; cfg_window = 16'd0;
      start = 1'b0; abort = 1'b0; data_valid = 1'b0; data = 1'b0;
      @(negedge clk);
      test_reset();
      test_overlap();
      test_no_overlap();
      test_target();
      test_both_limits();
      test_abort();
      test_len_default();
      test_short_gapped();
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
